// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core datapath and the external RAM port.
// Optional macro ROTATE_UNALIGNED_EN: unaligned word loads rotate, unaligned stores write aligned.
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              cs,
    output logic              we,
    output logic              oe,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byte_en,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);
    localparam bit               TimeoutEn  = (TIMEOUT_CYC != 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lat_we_q, lat_we_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              cs_q, cs_d;
    logic              ram_we_q, ram_we_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [3:0]        byte_en_q, byte_en_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_legal;
    logic [3:0]        req_be;
    logic [31:0]       req_wd;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_ext;

    // Request decode: legality, lane enables and lane-replicated store data.
    always_comb begin
        req_legal = 1'b0;
        req_be    = 4'b0000;
        req_wd    = req_wdata;
        case (req_size)
            2'b00: begin
                req_legal = 1'b1;
                req_be    = 4'b0001 << req_addr[1:0];
                req_wd    = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_legal = ~req_addr[0];
                req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd    = {2{req_wdata[15:0]}};
            end
            2'b10: begin
`ifdef ROTATE_UNALIGNED_EN
                req_legal = 1'b1;
`else
                req_legal = (req_addr[1:0] == 2'b00);
`endif
                req_be    = 4'b1111;
                req_wd    = req_wdata;
            end
            default: begin
                req_legal = 1'b0;
            end
        endcase
    end

    // Load data extraction from the latched offset/size/sign.
    always_comb begin
        rd_byte = ram_data_out[7:0];
        case (off_q)
            2'd0:    rd_byte = ram_data_out[7:0];
            2'd1:    rd_byte = ram_data_out[15:8];
            2'd2:    rd_byte = ram_data_out[23:16];
            default: rd_byte = ram_data_out[31:24];
        endcase
        rd_half = off_q[1] ? ram_data_out[31:16] : ram_data_out[15:0];
        rd_ext  = '0;
        case (size_q)
            2'b00:   rd_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            2'b10: begin
`ifdef ROTATE_UNALIGNED_EN
                case (off_q)
                    2'd0:    rd_ext = ram_data_out;
                    2'd1:    rd_ext = {ram_data_out[7:0], ram_data_out[31:8]};
                    2'd2:    rd_ext = {ram_data_out[15:0], ram_data_out[31:16]};
                    default: rd_ext = {ram_data_out[23:0], ram_data_out[31:24]};
                endcase
`else
                rd_ext = ram_data_out;
`endif
            end
            default: rd_ext = '0;
        endcase
    end

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = TimeoutEn && (cnt_inc == TimeoutVal);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_we_d  = lat_we_q;
        off_d     = off_q;
        size_d    = size_q;
        signed_d  = signed_q;
        cs_d      = cs_q;
        ram_we_d  = ram_we_q;
        oe_d      = oe_q;
        address_d = address_q;
        byte_en_d = byte_en_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    lat_we_d = req_we;
                    off_d    = req_addr[1:0];
                    size_d   = req_size;
                    signed_d = req_signed;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    if (req_legal) begin
                        state_d   = StAccess;
                        cs_d      = 1'b1;
                        ram_we_d  = req_we;
                        oe_d      = ~req_we;
                        address_d = {req_addr[ADDR_W-1:2], 2'b00};
                        byte_en_d = req_be;
                        wdata_d   = req_wd;
                        err_d     = 1'b0;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_inc;
                // ram_ready takes priority over a simultaneous timeout.
                if (ram_ready || timeout_hit) begin
                    state_d   = StResp;
                    cs_d      = 1'b0;
                    ram_we_d  = 1'b0;
                    oe_d      = 1'b0;
                    address_d = '0;
                    byte_en_d = '0;
                    wdata_d   = '0;
                    err_d     = ~ram_ready;
                    rdata_d   = (ram_ready && !lat_we_q) ? rd_ext : 32'h0;
                end
            end
            StResp: begin
                state_d = StIdle;
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            lat_we_q  <= 1'b0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            cs_q      <= 1'b0;
            ram_we_q  <= 1'b0;
            oe_q      <= 1'b0;
            address_q <= '0;
            byte_en_q <= 4'b0000;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_we_q  <= lat_we_d;
            off_q     <= off_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            cs_q      <= cs_d;
            ram_we_q  <= ram_we_d;
            oe_q      <= oe_d;
            address_q <= address_d;
            byte_en_q <= byte_en_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign cs          = cs_q;
    assign we          = ram_we_q;
    assign oe          = oe_q;
    assign address     = address_q;
    assign byte_en     = byte_en_q;
    assign ram_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit, built with a 4-cycle timeout.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cs, we, oe;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out = '0;
    logic        ram_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W     (32),
        .TIMEOUT_CYC(4),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .cs          (cs),
        .we          (we),
        .oe          (oe),
        .address     (address),
        .byte_en     (byte_en),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .ram_ready   (ram_ready)
    );

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          ready_cyc;  // ACCESS cycle in which ram_ready is raised, 0 = never
        int          exp_cs;
        int          exp_rsp;    // cycle index after acceptance holding rsp_valid
        logic [3:0]  exp_be;
        logic [31:0] exp_address;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic w, input logic [31:0] addr,
                                input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                                input logic [31:0] rd, input int ready_cyc, input int exp_cs,
                                input int exp_rsp, input logic [3:0] exp_be,
                                input logic [31:0] exp_address, input logic [31:0] exp_din,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.w = w; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
        v.rd = rd; v.ready_cyc = ready_cyc; v.exp_cs = exp_cs; v.exp_rsp = exp_rsp;
        v.exp_be = exp_be; v.exp_address = exp_address; v.exp_din = exp_din;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int          cs_cycles = 0;
        int          rsp_cyc = 0;
        logic [3:0]  be_s = '0;
        logic [31:0] addr_s = '0, din_s = '0, rdata_s = '0;
        logic        we_s = 1'b0, oe_s = 1'b0, err_s = 1'b0, rr_s = 1'b1, cs_rsp = 1'b1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.w;
        req_addr   = v.addr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_0000;
        for (int i = 1; i <= 30; i++) begin
            if (rsp_valid) begin
                rsp_cyc = i;
                rdata_s = rsp_rdata;
                err_s   = rsp_err;
                rr_s    = req_ready;
                cs_rsp  = cs;
                break;
            end
            if (cs) begin
                cs_cycles++;
                if (cs_cycles == 1) begin
                    be_s = byte_en; addr_s = address; din_s = ram_data_in; we_s = we; oe_s = oe;
                end
                ram_ready    = (cs_cycles == v.ready_cyc);
                ram_data_out = v.rd;
            end else begin
                ram_ready = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        ram_ready = 1'b0;
        chk({v.name, ".cs_cycles"}, cs_cycles, v.exp_cs);
        chk({v.name, ".rsp_cycle"}, rsp_cyc, v.exp_rsp);
        chk({v.name, ".rdata"}, rdata_s, v.exp_rdata);
        chk({v.name, ".err"}, {31'b0, err_s}, {31'b0, v.exp_err});
        chk({v.name, ".resp_strobes"}, {30'b0, rr_s, cs_rsp}, 32'h0);
        if (v.exp_cs != 0) begin
            chk({v.name, ".byte_en"}, {28'b0, be_s}, {28'b0, v.exp_be});
            chk({v.name, ".address"}, addr_s, v.exp_address);
            chk({v.name, ".we_oe"}, {30'b0, we_s, oe_s}, {30'b0, v.w, ~v.w});
            if (v.w) chk({v.name, ".ram_data_in"}, din_s, v.exp_din);
        end
        @(posedge clk);
        #1;
        chk({v.name, ".pulse_end"}, {30'b0, rsp_valid, req_ready}, 32'h1);
    endtask

    initial begin
        vecs.push_back(mk("ld_b_s_103", 0, 32'h103, 2'b00, 1, 0, 32'h80FF_1234, 2, 2, 3,
                          4'b1000, 32'h100, 0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk("ld_b_u_103", 0, 32'h103, 2'b00, 0, 0, 32'h80FF_1234, 1, 1, 2,
                          4'b1000, 32'h100, 0, 32'h0000_0080, 0));
        vecs.push_back(mk("ld_b_s_101", 0, 32'h101, 2'b00, 1, 0, 32'h80FF_1234, 1, 1, 2,
                          4'b0010, 32'h100, 0, 32'h0000_0012, 0));
        vecs.push_back(mk("st_h_202", 1, 32'h202, 2'b01, 0, 32'h0000_BEEF, 0, 1, 1, 2,
                          4'b1100, 32'h200, 32'hBEEF_BEEF, 0, 0));
        vecs.push_back(mk("ld_h_s_402", 0, 32'h402, 2'b01, 1, 0, 32'h80FF_1234, 1, 1, 2,
                          4'b1100, 32'h400, 0, 32'hFFFF_80FF, 0));
        vecs.push_back(mk("ld_h_u_400", 0, 32'h400, 2'b01, 0, 0, 32'h1234_ABCD, 1, 1, 2,
                          4'b0011, 32'h400, 0, 32'h0000_ABCD, 0));
        vecs.push_back(mk("ld_h_s_400", 0, 32'h400, 2'b01, 1, 0, 32'h1234_ABCD, 1, 1, 2,
                          4'b0011, 32'h400, 0, 32'hFFFF_ABCD, 0));
        vecs.push_back(mk("ld_w_500", 0, 32'h500, 2'b10, 1, 0, 32'h8765_4321, 1, 1, 2,
                          4'b1111, 32'h500, 0, 32'h8765_4321, 0));
        vecs.push_back(mk("st_w_600", 1, 32'h600, 2'b10, 0, 32'hDEAD_BEEF, 0, 3, 3, 4,
                          4'b1111, 32'h600, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk("st_b_701", 1, 32'h701, 2'b00, 0, 32'h1234_56A5, 0, 1, 1, 2,
                          4'b0010, 32'h700, 32'hA5A5_A5A5, 0, 0));
        vecs.push_back(mk("ld_h_mis_11", 0, 32'h11, 2'b01, 0, 0, 32'hFFFF_FFFF, 1, 0, 1,
                          0, 0, 0, 0, 1));
        vecs.push_back(mk("ld_rsv_20", 0, 32'h20, 2'b11, 0, 0, 32'hFFFF_FFFF, 1, 0, 1,
                          0, 0, 0, 0, 1));
        vecs.push_back(mk("ld_timeout", 0, 32'h800, 2'b10, 0, 0, 32'h5555_5555, 0, 4, 5,
                          4'b1111, 32'h800, 0, 0, 1));
        vecs.push_back(mk("ld_after_to", 0, 32'h804, 2'b10, 0, 0, 32'h0BAD_F00D, 1, 1, 2,
                          4'b1111, 32'h804, 0, 32'h0BAD_F00D, 0));
        vecs.push_back(mk("ld_h_mis_403", 0, 32'h403, 2'b01, 1, 0, 32'hFFFF_FFFF, 1, 0, 1,
                          0, 0, 0, 0, 1));
`ifdef ROTATE_UNALIGNED_EN
        vecs.push_back(mk("ld_w_301", 0, 32'h301, 2'b10, 0, 0, 32'h4433_2211, 1, 1, 2,
                          4'b1111, 32'h300, 0, 32'h1144_3322, 0));
        vecs.push_back(mk("st_w_302", 1, 32'h302, 2'b10, 0, 32'hCAFE_F00D, 0, 1, 1, 2,
                          4'b1111, 32'h300, 32'hCAFE_F00D, 0, 0));
`else
        vecs.push_back(mk("ld_w_301", 0, 32'h301, 2'b10, 0, 0, 32'h4433_2211, 1, 0, 1,
                          0, 0, 0, 0, 1));
        vecs.push_back(mk("st_w_302", 1, 32'h302, 2'b10, 0, 32'hCAFE_F00D, 0, 1, 0, 1,
                          0, 0, 0, 0, 1));
`endif

        // Reset state.
        #12;
        chk("reset.outputs", {23'b0, cs, we, oe, rsp_valid, rsp_err, byte_en},
            32'h0);
        chk("reset.req_ready", {31'b0, req_ready}, 32'h1);
        chk("reset.address_data", address | ram_data_in | rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during ACCESS: strobes drop at once and no response follows.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h900; req_size = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.cs_before", {31'b0, cs}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid.strobes_async", {29'b0, cs, we, oe}, 32'h0);
        chk("mid.req_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        begin
            logic seen = 1'b0;
            logic busy = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                seen |= rsp_valid;
                busy |= ~req_ready;
            end
            chk("mid.no_rsp", {31'b0, seen}, 32'h0);
            chk("mid.idle_after", {31'b0, busy}, 32'h0);
        end
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
